// File: rtl/oled_framebuffer.sv
// Page-organised monochrome frame buffer between a drawing client and an OLED controller.
// Ports: in_clk/in_rst (sync, active-high); pixel set/clear (in_pix_*), screen fill
// (in_clear, in_clear_val), out_pix_ready handshake; display read (in_hpix, in_vpage ->
// out_pixels, 1-cycle latency); out_update = frame-dirty level.
module oled_framebuffer #(
   parameter int SERIAL_BITS   = 8,
   parameter int SCREEN_WIDTH  = 128,
   parameter int SCREEN_HEIGHT = 64,
   parameter int SCREEN_PAGES  = SCREEN_HEIGHT / SERIAL_BITS,
   parameter int HCTR_BITS     = $clog2(SCREEN_WIDTH),
   parameter int VCTR_BITS     = $clog2(SCREEN_HEIGHT),
   parameter int PAGE_BITS     = $clog2(SCREEN_PAGES)
) (
   input  logic                   in_clk,
   input  logic                   in_rst,
   input  logic                   in_pix_write,
   input  logic [HCTR_BITS-1:0]   in_pix_x,
   input  logic [VCTR_BITS-1:0]   in_pix_y,
   input  logic                   in_pix_val,
   input  logic                   in_clear,
   input  logic                   in_clear_val,
   output logic                   out_pix_ready,
   input  logic [HCTR_BITS-1:0]   in_hpix,
   input  logic [PAGE_BITS-1:0]   in_vpage,
   output logic [SERIAL_BITS-1:0] out_pixels,
   output logic                   out_update
);

   localparam int NBYTES   = SCREEN_WIDTH * SCREEN_PAGES;
   localparam int IDX_BITS = $clog2(NBYTES);
   localparam int BIT_BITS = $clog2(SERIAL_BITS);
   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NBYTES - 1);

   typedef enum logic [1:0] {
      S_CLEAR,
      S_IDLE,
      S_PIXREAD,
      S_PIXWRITE
   } state_e;

   state_e                 state_q, state_d;
   logic [IDX_BITS-1:0]    ctr_q, ctr_d;
   logic                   fill_q, fill_d;
   logic [HCTR_BITS-1:0]   x_q, x_d;
   logic [VCTR_BITS-1:0]   y_q, y_d;
   logic                   val_q, val_d;
   logic                   dirty_q, dirty_d;
   logic [HCTR_BITS-1:0]   hpix_q;
   logic [PAGE_BITS-1:0]   vpage_q;
   logic [SERIAL_BITS-1:0] pix_rd_q;
   logic [SERIAL_BITS-1:0] pixels_q;

   logic [SERIAL_BITS-1:0] mem [NBYTES];

   logic                   we;
   logic [IDX_BITS-1:0]    waddr;
   logic [SERIAL_BITS-1:0] wdata;
   logic                   set_dirty;
   logic                   in_range;
   logic                   frame_start;
   logic [IDX_BITS-1:0]    pix_idx;
   logic [IDX_BITS-1:0]    disp_idx;
   logic [BIT_BITS-1:0]    pix_bit;

   assign pix_idx  = IDX_BITS'((int'(y_q) / SERIAL_BITS) * SCREEN_WIDTH
                               + int'(x_q));
   assign pix_bit  = BIT_BITS'(int'(y_q) % SERIAL_BITS);
   assign disp_idx = IDX_BITS'(int'(in_vpage) * SCREEN_WIDTH
                               + int'(in_hpix));
   assign in_range = (int'(in_pix_x) < SCREEN_WIDTH)
                  && (int'(in_pix_y) < SCREEN_HEIGHT);

   // Display moving from column 0 to column 1 of page 0 marks a new frame transfer.
   assign frame_start = (hpix_q == '0) && (vpage_q == '0)
                     && (in_hpix == HCTR_BITS'(1)) && (in_vpage == '0);

   always_comb begin
      state_d   = state_q;
      ctr_d     = ctr_q;
      fill_d    = fill_q;
      x_d       = x_q;
      y_d       = y_q;
      val_d     = val_q;
      we        = 1'b0;
      waddr     = ctr_q;
      wdata     = {SERIAL_BITS{fill_q}};
      set_dirty = 1'b0;
      unique case (state_q)
         S_CLEAR: begin
            we    = 1'b1;
            ctr_d = ctr_q + 1'b1;
            if (ctr_q == LAST_IDX) begin
               ctr_d     = '0;
               state_d   = S_IDLE;
               set_dirty = 1'b1;
            end
         end
         S_IDLE: begin
            if (in_clear) begin
               fill_d  = in_clear_val;
               ctr_d   = '0;
               state_d = S_CLEAR;
            end else if (in_pix_write) begin
               x_d   = in_pix_x;
               y_d   = in_pix_y;
               val_d = in_pix_val;
               // Off-screen requests are consumed without effect.
               if (in_range) state_d = S_PIXREAD;
            end
         end
         S_PIXREAD: begin
            state_d = S_PIXWRITE;
         end
         S_PIXWRITE: begin
            we             = 1'b1;
            waddr          = pix_idx;
            wdata          = pix_rd_q;
            wdata[pix_bit] = val_q;
            set_dirty      = 1'b1;
            state_d        = S_IDLE;
         end
         default: begin
            state_d = S_CLEAR;
         end
      endcase
   end

   // Set has priority over the frame-start clear.
   assign dirty_d = set_dirty | (dirty_q & ~frame_start);

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state_q <= S_CLEAR;
         ctr_q   <= '0;
         fill_q  <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         val_q   <= 1'b0;
         dirty_q <= 1'b0;
         hpix_q  <= '0;
         vpage_q <= '0;
      end else begin
         state_q <= state_d;
         ctr_q   <= ctr_d;
         fill_q  <= fill_d;
         x_q     <= x_d;
         y_q     <= y_d;
         val_q   <= val_d;
         dirty_q <= dirty_d;
         hpix_q  <= in_hpix;
         vpage_q <= in_vpage;
      end
   end

   // Storage is not reset; the post-reset fill initialises it.
   always_ff @(posedge in_clk) begin
      if (we) mem[waddr] <= wdata;
      pix_rd_q <= mem[pix_idx];
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) pixels_q <= '0;
      else        pixels_q <= mem[disp_idx];
   end

   assign out_pix_ready = (state_q == S_IDLE);
   assign out_pixels    = pixels_q;
   assign out_update    = dirty_q;

endmodule

// File: tb/tb_oled_framebuffer.sv
// Directed bench for oled_framebuffer: reset fill, pixel set/clear, back-to-back
// writes, fill priority, dirty-flag handling and reset during a fill.
module tb_oled_framebuffer;

   localparam int HB = 7;
   localparam int VB = 6;
   localparam int PB = 3;

   logic          in_clk = 1'b0;
   logic          in_rst;
   logic          in_pix_write;
   logic [HB-1:0] in_pix_x;
   logic [VB-1:0] in_pix_y;
   logic          in_pix_val;
   logic          in_clear;
   logic          in_clear_val;
   logic          out_pix_ready;
   logic [HB-1:0] in_hpix;
   logic [PB-1:0] in_vpage;
   logic [7:0]    out_pixels;
   logic          out_update;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 in_clk = ~in_clk;

   oled_framebuffer dut (
      .in_clk        (in_clk),
      .in_rst        (in_rst),
      .in_pix_write  (in_pix_write),
      .in_pix_x      (in_pix_x),
      .in_pix_y      (in_pix_y),
      .in_pix_val    (in_pix_val),
      .in_clear      (in_clear),
      .in_clear_val  (in_clear_val),
      .out_pix_ready (out_pix_ready),
      .in_hpix       (in_hpix),
      .in_vpage      (in_vpage),
      .out_pixels    (out_pixels),
      .out_update    (out_update)
   );

   task automatic tick;
      @(posedge in_clk);
      #1;
   endtask

   task automatic rd(input int h, input int p, output logic [7:0] d);
      in_hpix  = HB'(h);
      in_vpage = PB'(p);
      tick;
      d = out_pixels;
   endtask

   task automatic do_pix(input int x, input int y, input logic v);
      in_pix_write = 1'b1;
      in_pix_x     = HB'(x);
      in_pix_y     = VB'(y);
      in_pix_val   = v;
      tick;
      in_pix_write = 1'b0;
      tick;
      tick;
   endtask

   task automatic test_reset;
      logic [7:0] d;
      logic       exp;
      in_rst = 1'b1;
      repeat (3) tick;
      n_cmp++;
      if (out_pix_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_ready got %b want 0", out_pix_ready);
      end
      n_cmp++;
      if (out_update !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_update got %b want 0", out_update);
      end
      n_cmp++;
      if (out_pixels !== 8'h00) begin
         n_bad++;
         $display("FAIL rst_pixels got %h want 00", out_pixels);
      end
      in_rst = 1'b0;
      for (int k = 1; k <= 1100; k++) begin
         tick;
         exp = (k >= 1024);
         n_cmp++;
         if (out_pix_ready !== exp) begin
            n_bad++;
            $display("FAIL init_ready cycle %0d got %b want %b",
                     k, out_pix_ready, exp);
         end
      end
      n_cmp++;
      if (out_update !== 1'b1) begin
         n_bad++;
         $display("FAIL init_update got %b want 1", out_update);
      end
      rd(0, 0, d);
      n_cmp++;
      if (d !== 8'h00) begin
         n_bad++;
         $display("FAIL init_rd_0_0 got %h want 00", d);
      end
      rd(127, 7, d);
      n_cmp++;
      if (d !== 8'h00) begin
         n_bad++;
         $display("FAIL init_rd_127_7 got %h want 00", d);
      end
      rd(64, 3, d);
      n_cmp++;
      if (d !== 8'h00) begin
         n_bad++;
         $display("FAIL init_rd_64_3 got %h want 00", d);
      end
   endtask

   task automatic test_pixel;
      logic [7:0] d;
      n_cmp++;
      if (out_pix_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL pix_ready_pre got %b want 1", out_pix_ready);
      end
      in_pix_write = 1'b1;
      in_pix_x     = 7'd5;
      in_pix_y     = 6'd10;
      in_pix_val   = 1'b1;
      tick;
      in_pix_write = 1'b0;
      n_cmp++;
      if (out_pix_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL pix_ready_e1 got %b want 0", out_pix_ready);
      end
      tick;
      n_cmp++;
      if (out_pix_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL pix_ready_e2 got %b want 0", out_pix_ready);
      end
      tick;
      n_cmp++;
      if (out_pix_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL pix_ready_e3 got %b want 1", out_pix_ready);
      end
      n_cmp++;
      if (out_update !== 1'b1) begin
         n_bad++;
         $display("FAIL pix_update got %b want 1", out_update);
      end
      rd(5, 1, d);
      n_cmp++;
      if (d !== 8'h04) begin
         n_bad++;
         $display("FAIL pix_rd_5_1 got %h want 04", d);
      end
      rd(4, 1, d);
      n_cmp++;
      if (d !== 8'h00) begin
         n_bad++;
         $display("FAIL pix_rd_4_1 got %h want 00", d);
      end
      rd(5, 0, d);
      n_cmp++;
      if (d !== 8'h00) begin
         n_bad++;
         $display("FAIL pix_rd_5_0 got %h want 00", d);
      end
   endtask

   task automatic test_modify;
      logic [7:0] d;
      do_pix(5, 11, 1'b1);
      rd(5, 1, d);
      n_cmp++;
      if (d !== 8'h0c) begin
         n_bad++;
         $display("FAIL mod_set11 got %h want 0c", d);
      end
      do_pix(5, 10, 1'b0);
      rd(5, 1, d);
      n_cmp++;
      if (d !== 8'h08) begin
         n_bad++;
         $display("FAIL mod_clr10 got %h want 08", d);
      end
      do_pix(3, 8, 1'b1);
      rd(3, 1, d);
      n_cmp++;
      if (d !== 8'h01) begin
         n_bad++;
         $display("FAIL mod_top_row got %h want 01", d);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] d;
      do_pix(7, 63, 1'b1);
      n_cmp++;
      if (out_pix_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL b2b_ready got %b want 1", out_pix_ready);
      end
      do_pix(7, 62, 1'b1);
      rd(7, 7, d);
      n_cmp++;
      if (d !== 8'hc0) begin
         n_bad++;
         $display("FAIL b2b_rd_7_7 got %h want c0", d);
      end
   endtask

   task automatic test_clear_priority;
      logic [7:0] d;
      logic       exp;
      in_clear     = 1'b1;
      in_clear_val = 1'b1;
      in_pix_write = 1'b1;
      in_pix_x     = 7'd9;
      in_pix_y     = 6'd0;
      in_pix_val   = 1'b0;
      tick;
      in_clear     = 1'b0;
      in_pix_write = 1'b0;
      n_cmp++;
      if (out_pix_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL clr_ready_c0 got %b want 0", out_pix_ready);
      end
      for (int k = 1; k <= 1024; k++) begin
         tick;
         exp = (k >= 1024);
         n_cmp++;
         if (out_pix_ready !== exp) begin
            n_bad++;
            $display("FAIL clr_ready cycle %0d got %b want %b",
                     k, out_pix_ready, exp);
         end
      end
      rd(0, 0, d);
      n_cmp++;
      if (d !== 8'hff) begin
         n_bad++;
         $display("FAIL clr_rd_0_0 got %h want ff", d);
      end
      rd(127, 7, d);
      n_cmp++;
      if (d !== 8'hff) begin
         n_bad++;
         $display("FAIL clr_rd_127_7 got %h want ff", d);
      end
      rd(9, 0, d);
      n_cmp++;
      if (d !== 8'hff) begin
         n_bad++;
         $display("FAIL clr_rd_9_0 got %h want ff", d);
      end
      rd(0, 0, d);
   endtask

   task automatic test_dirty;
      logic [7:0] d;
      n_cmp++;
      if (out_update !== 1'b1) begin
         n_bad++;
         $display("FAIL dirty_pre got %b want 1", out_update);
      end
      in_hpix  = 7'd0;
      in_vpage = 3'd0;
      tick;
      in_hpix = 7'd1;
      tick;
      n_cmp++;
      if (out_update !== 1'b0) begin
         n_bad++;
         $display("FAIL dirty_frame_clr got %b want 0", out_update);
      end
      in_hpix = 7'd0;
      tick;
      n_cmp++;
      if (out_update !== 1'b0) begin
         n_bad++;
         $display("FAIL dirty_stays_low got %b want 0", out_update);
      end
      in_pix_write = 1'b1;
      in_pix_x     = 7'd20;
      in_pix_y     = 6'd20;
      in_pix_val   = 1'b0;
      tick;
      in_pix_write = 1'b0;
      tick;
      in_hpix = 7'd1;
      tick;
      n_cmp++;
      if (out_update !== 1'b1) begin
         n_bad++;
         $display("FAIL dirty_set_wins got %b want 1", out_update);
      end
      rd(20, 2, d);
      n_cmp++;
      if (d !== 8'hef) begin
         n_bad++;
         $display("FAIL dirty_rd_20_2 got %h want ef", d);
      end
      rd(0, 0, d);
   endtask

   task automatic test_reset_mid_clear;
      logic [7:0] d;
      logic       exp;
      int         bad;
      in_clear     = 1'b1;
      in_clear_val = 1'b1;
      tick;
      in_clear = 1'b0;
      repeat (500) tick;
      in_rst = 1'b1;
      tick;
      in_rst = 1'b0;
      n_cmp++;
      if (out_pix_ready !== 1'b0 || out_update !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_rst_outs got rdy=%b upd=%b want 0 0",
                  out_pix_ready, out_update);
      end
      for (int k = 1; k <= 1024; k++) begin
         tick;
         exp = (k >= 1024);
         n_cmp++;
         if (out_pix_ready !== exp) begin
            n_bad++;
            $display("FAIL mid_rst_ready cycle %0d got %b want %b",
                     k, out_pix_ready, exp);
         end
      end
      n_cmp++;
      if (out_update !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_rst_update got %b want 1", out_update);
      end
      bad = 0;
      for (int p = 0; p < 8; p++) begin
         for (int h = 0; h < 128; h++) begin
            rd(h, p, d);
            if (d !== 8'h00) begin
               if (bad < 4)
                  $display("FAIL mid_rst_byte (%0d,%0d) got %h want 00",
                           h, p, d);
               bad++;
            end
         end
      end
      n_cmp++;
      if (bad !== 0) begin
         n_bad++;
         $display("FAIL mid_rst_sweep got %0d bad bytes want 0", bad);
      end
   endtask

   initial begin
      in_rst       = 1'b1;
      in_pix_write = 1'b0;
      in_pix_x     = '0;
      in_pix_y     = '0;
      in_pix_val   = 1'b0;
      in_clear     = 1'b0;
      in_clear_val = 1'b0;
      in_hpix      = '0;
      in_vpage     = '0;
      test_reset;
      test_pixel;
      test_modify;
      test_back_to_back;
      test_clear_priority;
      test_dirty;
      test_reset_mid_clear;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
